// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and operand-sign helpers for the RV64M unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic a_signed(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_signed(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : One-bit-per-cycle shift-add multiply / restoring divide core.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_mag_a,
    input  logic [XLEN-1:0] i_mag_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo,
    output logic            o_last
);

    localparam int c_CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    r_m;
    logic               r_div;
    logic [c_CNT_W-1:0] r_cnt;

    logic [XLEN:0]      w_add;
    logic [XLEN:0]      w_shift;
    logic [XLEN-1:0]    w_diff;
    logic               w_ge;
    logic [XLEN-1:0]    w_hi_nxt;
    logic [XLEN-1:0]    w_lo_nxt;

    // hi:lo is the product (mul) or remainder:quotient-with-dividend (div).
    // When the subtract succeeds the true difference is below 2^XLEN,
    // so an XLEN-wide subtraction is exact.
    always_comb begin
        w_add    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        w_shift  = {r_hi, r_lo[XLEN-1]};
        w_ge     = (w_shift >= {1'b0, r_m});
        w_diff   = w_shift[XLEN-1:0] - r_m;
        w_hi_nxt = w_add[XLEN:1];
        w_lo_nxt = {w_add[0], r_lo[XLEN-1:1]};
        if (r_div) begin
            w_hi_nxt = w_ge ? w_diff : w_shift[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_m   <= '0;
            r_div <= 1'b0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_mag_a;
            r_m   <= i_mag_b;
            r_div <= i_is_div;
            r_cnt <= '0;
        end else if (i_step) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_last = (r_cnt == c_CNT_W'(XLEN-1));

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV64M multiply/divide unit with busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            write_en,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_data
);

    muldiv_state_t   r_state;
    muldiv_state_t   w_state_nxt;
    muldiv_op_t      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [4:0]      r_rd;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_special;
    logic [XLEN-1:0] r_spec_val;
    logic [XLEN-1:0] r_rd_data;

    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_spec_val;
    logic            w_load;
    logic            w_step;
    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_lo;
    logic            w_last;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_result;

    // Sign handling and special-case detection, consumed in PREP.
    always_comb begin
        w_a_neg    = a_signed(r_op) & r_a[XLEN-1];
        w_b_neg    = b_signed(r_op) & r_b[XLEN-1];
        w_mag_a    = w_a_neg ? (~r_a + 1'b1) : r_a;
        w_mag_b    = w_b_neg ? (~r_b + 1'b1) : r_b;
        w_div0     = is_div(r_op) && (r_b == '0);
        w_ovf      = ((r_op == OP_DIV) || (r_op == OP_REM)) &&
                     (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (r_b == '1);
        w_spec_val = '0;
        if (w_div0) begin
            w_spec_val = ((r_op == OP_DIV) || (r_op == OP_DIVU)) ? '1 : r_a;
        end else if (w_ovf) begin
            w_spec_val = (r_op == OP_DIV) ? r_a : '0;
        end
    end

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_is_div (is_div(r_op)),
        .i_mag_a  (w_mag_a),
        .i_mag_b  (w_mag_b),
        .o_hi     (w_hi),
        .o_lo     (w_lo),
        .o_last   (w_last)
    );

    always_comb begin
        w_prod = {w_hi, w_lo};
        if (r_neg_q) w_prod = ~w_prod + 1'b1;
        w_quo  = r_neg_q ? (~w_lo + 1'b1) : w_lo;
        w_rem  = r_neg_r ? (~w_hi + 1'b1) : w_hi;
        case (r_op)
            OP_MUL:                       w_result = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_result = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_result = w_quo;
            default:                      w_result = w_rem;
        endcase
        if (r_special) w_result = r_spec_val;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_PREP;
            ST_PREP: begin
                w_load      = 1'b1;
                w_state_nxt = (w_div0 || w_ovf) ? ST_FIX : ST_RUN;
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) w_state_nxt = ST_FIX;
            end
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_MUL;
            r_a        <= '0;
            r_b        <= '0;
            r_rd       <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
            r_rd_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && start) begin
                r_op <= muldiv_op_t'(funct3);
                r_a  <= rs1_data;
                r_b  <= rs2_data;
                r_rd <= rd_in;
            end
            if (r_state == ST_PREP) begin
                r_neg_q    <= w_a_neg ^ w_b_neg;
                r_neg_r    <= w_a_neg;
                r_special  <= w_div0 | w_ovf;
                r_spec_val <= w_spec_val;
            end
            if (r_state == ST_FIX) r_rd_data <= w_result;
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign write_en = done;
    assign rd       = r_rd;
    assign rd_data  = r_rd_data;

endmodule
`default_nettype wire
